// File: rtl/screen_reader.sv
// screen_reader: 640x480@60 VGA scan-out of a 512x256 monochrome framebuffer.
// The image is centred in the active area, the rest of the active area is
// painted BORDER_RGB, and framebuffer words are prefetched one word ahead
// through a registered-address read port.
//
// Fetch FSM
//   state   | meaning
//   IDLE    | waiting for the fetch slot 8 ticks ahead of the next image word
//   ISSUE   | rd_en high for one clk, rd_addr holds the wanted word
//   CAPTURE | rd_data valid, latched into the prefetch register
module screen_reader #(
   parameter int          CLK_DIV     = 2,
   parameter logic [14:0] SCREEN_BASE = 15'h4000,
   parameter logic [11:0] FG_RGB      = 12'hFFF,
   parameter logic [11:0] BG_RGB      = 12'h000,
   parameter logic [11:0] BORDER_RGB  = 12'h00F
) (
   input  logic        clk,
   input  logic        reset,
   output logic [14:0] rd_addr,
   output logic        rd_en,
   input  logic [15:0] rd_data,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [11:0] rgb,
   output logic        frame_start
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } fetch_state_t;

   logic [DIV_W-1:0] div_q;
   logic [9:0]       h_q;
   logic [9:0]       v_q;
   fetch_state_t     state_q;
   logic [15:0]      pref_q;
   logic [15:0]      shift_q;
   logic [14:0]      rd_addr_q;
   logic             rd_en_q;
   logic             hsync_q;
   logic             vsync_q;
   logic             de_q;
   logic [11:0]      rgb_q;
   logic             frame_start_q;

   logic        tick;
   logic        h_end;
   logic        v_end;
   logic [9:0]  img_y;
   logic [9:0]  fetch_x;
   logic        img_row;
   logic        in_img;
   logic        fetch_hit;
   logic        load_hit;
   logic        de_d;
   logic        hsync_d;
   logic        vsync_d;
   logic        pixel_d;
   logic [11:0] rgb_d;
   logic [15:0] shift_d;
   logic [14:0] fetch_addr;

   assign tick  = (div_q == DIV_W'(CLK_DIV - 1));
   assign h_end = (h_q == 10'd799);
   assign v_end = (v_q == 10'd524);

   // Position decode for the current (h,v): sync, window, fetch and load slots.
   always_comb begin
      img_y   = v_q - 10'd112;
      fetch_x = h_q - 10'd56;
      // rows 112..367: v above 111 and v-112 below 256
      img_row = (v_q >= 10'd112) && (img_y[9:8] == 2'b00);
      in_img  = img_row && (h_q >= 10'd64) && (h_q < 10'd576);
      // slots h = 56 + 16k, k = 0..31
      fetch_hit = img_row && (h_q >= 10'd56) && (fetch_x[9:4] < 6'd32)
                  && (fetch_x[3:0] == 4'd0);
      // 64 is a multiple of 16, so word boundaries sit on h[3:0] == 0
      load_hit   = in_img && (h_q[3:0] == 4'd0);
      fetch_addr = SCREEN_BASE + {2'b00, img_y[7:0], fetch_x[8:4]};
      de_d       = (h_q < 10'd640) && (v_q < 10'd480);
      hsync_d    = !((h_q >= 10'd656) && (h_q <= 10'd751));
      vsync_d    = !((v_q >= 10'd490) && (v_q <= 10'd491));
      // on a load tick the word's bit 0 is shown straight from the prefetch
      pixel_d    = load_hit ? pref_q[0] : shift_q[0];
      shift_d    = load_hit ? {1'b0, pref_q[15:1]} : {1'b0, shift_q[15:1]};
      rgb_d      = 12'h000;
      if (de_d) begin
         if (in_img) rgb_d = pixel_d ? FG_RGB : BG_RGB;
         else        rgb_d = BORDER_RGB;
      end
   end

   // Pixel divider and raster counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q <= '0;
         h_q   <= '0;
         v_q   <= '0;
      end else begin
         div_q <= tick ? '0 : div_q + 1'b1;
         if (tick) begin
            if (h_end) begin
               h_q <= '0;
               v_q <= v_end ? 10'd0 : v_q + 10'd1;
            end else begin
               h_q <= h_q + 10'd1;
            end
         end
      end
   end

   // Registered video outputs and the pixel shifter, updated on ticks only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         de_q          <= 1'b0;
         rgb_q         <= 12'h000;
         shift_q       <= 16'h0000;
         frame_start_q <= 1'b0;
      end else begin
         frame_start_q <= tick && (h_q == 10'd0) && (v_q == 10'd0);
         if (tick) begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            rgb_q   <= rgb_d;
            shift_q <= shift_d;
         end
      end
   end

   // Fetch FSM: one read per image word, issued 8 ticks before it is shown.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         rd_en_q   <= 1'b0;
         rd_addr_q <= SCREEN_BASE;
         pref_q    <= 16'h0000;
      end else begin
         case (state_q)
            IDLE: begin
               rd_en_q <= 1'b0;
               if (tick && fetch_hit) begin
                  state_q   <= ISSUE;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= fetch_addr;
               end
            end
            ISSUE: begin
               rd_en_q <= 1'b0;
               state_q <= CAPTURE;
            end
            CAPTURE: begin
               pref_q  <= rd_data;
               state_q <= IDLE;
            end
            default: begin
               rd_en_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign rd_addr     = rd_addr_q;
   assign rd_en       = rd_en_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign rgb         = rgb_q;
   assign frame_start = frame_start_q;

endmodule
